// File: rtl/alu_share_arbiter_if.sv
// Bundle between the execution units / ALU and the shared-ALU arbiter.
// Handshake: a requester holds req[i] high with stable operands until it sees resp_valid[i]
// (a one-cycle pulse) and then drops req[i] at that edge; grant[i] marks the cycle its operands drive the ALU.
interface alu_share_arbiter_if #(
  parameter int XLEN    = 32,
  parameter int NUM_REQ = 3,
  parameter int OP_W    = 3
);
  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0]      req;
  logic [NUM_REQ*XLEN-1:0] req_a;
  logic [NUM_REQ*XLEN-1:0] req_b;
  logic [NUM_REQ*OP_W-1:0] req_op;
  logic [NUM_REQ-1:0]      grant;
  logic [NUM_REQ-1:0]      resp_valid;
  logic [XLEN-1:0]         resp_data;
  logic [XLEN-1:0]         alu_a;
  logic [XLEN-1:0]         alu_b;
  logic [OP_W-1:0]         alu_op;
  logic [XLEN-1:0]         alu_out;
  logic                    busy;
  logic [1:0]              dbg_state;
  logic [IDX_W-1:0]        dbg_last_owner;

  modport master (
    output req, req_a, req_b, req_op, alu_out,
    input  grant, resp_valid, resp_data, alu_a, alu_b, alu_op, busy, dbg_state, dbg_last_owner
  );

  modport slave (
    input  req, req_a, req_b, req_op, alu_out,
    output grant, resp_valid, resp_data, alu_a, alu_b, alu_op, busy, dbg_state, dbg_last_owner
  );
endinterface

// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between NUM_REQ execution units.
// Each op takes EXEC (operands on the ALU) then RESP (result pulse); RESP may chain straight into the next EXEC.
module alu_share_arbiter #(
  parameter int XLEN    = 32,
  parameter int NUM_REQ = 3,
  parameter int OP_W    = 3
) (
  input  logic clk,
  input  logic reset,
  alu_share_arbiter_if.slave bus
);
  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   owner_q, owner_d;
  logic [IDX_W-1:0]   last_q, last_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [NUM_REQ-1:0] rv_q, rv_d;
  logic [XLEN-1:0]    rdata_q, rdata_d;
  logic [XLEN-1:0]    a_q, a_d;
  logic [XLEN-1:0]    b_q, b_d;
  logic [OP_W-1:0]    op_q, op_d;

  logic [NUM_REQ-1:0] elig;
  logic               win_found;
  logic [IDX_W-1:0]   win;

  function automatic logic [NUM_REQ-1:0] onehot(input logic [IDX_W-1:0] i);
    onehot = {{(NUM_REQ-1){1'b0}}, 1'b1} << i;
  endfunction

  // The owner just served is masked in RESP so it cannot win twice back to back.
  always_comb begin
    elig = '0;
    case (state_q)
      IDLE:    elig = bus.req;
      RESP:    elig = bus.req & ~onehot(owner_q);
      default: elig = '0;
    endcase
  end

  always_comb begin
    win_found = 1'b0;
    win       = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!win_found && elig[IDX_W'((int'(last_q) + 1 + k) % NUM_REQ)]) begin
        win_found = 1'b1;
        win       = IDX_W'((int'(last_q) + 1 + k) % NUM_REQ);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    grant_d = '0;
    rv_d    = '0;
    rdata_d = rdata_q;
    a_d     = '0;
    b_d     = '0;
    op_d    = '0;
    case (state_q)
      IDLE, RESP: begin
        if (win_found) begin
          state_d = EXEC;
          owner_d = win;
          last_d  = win;
          grant_d = onehot(win);
          a_d     = bus.req_a[int'(win)*XLEN +: XLEN];
          b_d     = bus.req_b[int'(win)*XLEN +: XLEN];
          op_d    = bus.req_op[int'(win)*OP_W +: OP_W];
        end else begin
          state_d = IDLE;
        end
      end
      EXEC: begin
        rdata_d = bus.alu_out;
        rv_d    = onehot(owner_q);
        state_d = RESP;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      owner_q <= '0;
      last_q  <= IDX_W'(NUM_REQ - 1);
      grant_q <= '0;
      rv_q    <= '0;
      rdata_q <= '0;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      grant_q <= grant_d;
      rv_q    <= rv_d;
      rdata_q <= rdata_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
    end
  end

  assign bus.grant          = grant_q;
  assign bus.resp_valid     = rv_q;
  assign bus.resp_data      = rdata_q;
  assign bus.alu_a          = a_q;
  assign bus.alu_b          = b_q;
  assign bus.alu_op         = op_q;
  assign bus.busy           = (state_q != IDLE);
  assign bus.dbg_state      = state_q;
  assign bus.dbg_last_owner = last_q;
endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter with a two-op ALU model (0: a+b, 1: a-b).
module tb_alu_share_arbiter;
  localparam int XLEN = 32;
  localparam int NREQ = 3;
  localparam int OPW  = 3;

  logic clk = 1'b0;
  logic reset;
  int   n_total = 0;
  int   n_pass  = 0;
  logic [XLEN-1:0] exp_q[$];

  alu_share_arbiter_if #(.XLEN(XLEN), .NUM_REQ(NREQ), .OP_W(OPW)) aif ();

  alu_share_arbiter #(.XLEN(XLEN), .NUM_REQ(NREQ), .OP_W(OPW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (aif)
  );

  assign aif.alu_out = (aif.alu_op == 3'd1) ? (aif.alu_a - aif.alu_b) : (aif.alu_a + aif.alu_b);

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish, got running expected done");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset   = 1'b1;
    aif.req = '0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic set_op(input int i, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                        input logic [OPW-1:0] op);
    aif.req_a[i*XLEN +: XLEN] = a;
    aif.req_b[i*XLEN +: XLEN] = b;
    aif.req_op[i*OPW +: OPW]  = op;
  endtask

  function automatic logic [NREQ-1:0] oh(input int i);
    return NREQ'(1 << i);
  endfunction

  initial begin
    logic req1_low;
    logic req2_low;
    reset      = 1'b1;
    aif.req    = '0;
    aif.req_a  = '0;
    aif.req_b  = '0;
    aif.req_op = '0;

    // reset state
    do_reset();
    chk("rst_grant", aif.grant, 0);
    chk("rst_resp_valid", aif.resp_valid, 0);
    chk("rst_resp_data", aif.resp_data, 0);
    chk("rst_alu_a", aif.alu_a, 0);
    chk("rst_alu_b", aif.alu_b, 0);
    chk("rst_alu_op", aif.alu_op, 0);
    chk("rst_busy", aif.busy, 0);
    chk("rst_last_owner", aif.dbg_last_owner, 2);

    // single request from requester 1
    set_op(1, 32'd5, 32'd3, 3'd0);
    aif.req = 3'b010;
    tick();
    chk("t1_grant", aif.grant, 3'b010);
    chk("t1_alu_a", aif.alu_a, 5);
    chk("t1_alu_b", aif.alu_b, 3);
    chk("t1_resp_valid_c1", aif.resp_valid, 0);
    chk("t1_busy", aif.busy, 1);
    tick();
    chk("t1_resp_valid", aif.resp_valid, 3'b010);
    chk("t1_resp_data", aif.resp_data, 8);
    chk("t1_grant_c2", aif.grant, 0);
    aif.req = '0;
    tick();
    chk("t1_idle", aif.busy, 0);
    chk("t1_rv_clear", aif.resp_valid, 0);
    chk("t1_data_hold", aif.resp_data, 8);

    // all three requesting, round robin from requester 0
    do_reset();
    set_op(0, 32'd10, 32'd20, 3'd0);
    set_op(1, 32'd50, 32'd8, 3'd1);
    set_op(2, 32'd7, 32'd7, 3'd0);
    exp_q   = '{32'd30, 32'd42, 32'd14};
    aif.req = 3'b111;
    for (int c = 1; c <= 6; c++) begin
      tick();
      chk("t2_grant", aif.grant, (c % 2 == 1) ? oh((c - 1) / 2) : 3'b000);
      chk("t2_resp_valid", aif.resp_valid, (c % 2 == 0) ? oh(c / 2 - 1) : 3'b000);
      chk("t2_exclusive", aif.grant & aif.resp_valid, 0);
      if (aif.resp_valid != 0) begin
        if (exp_q.size() > 0) chk("t2_resp_data", aif.resp_data, exp_q.pop_front());
        else chk("t2_unexpected_resp", aif.resp_valid, 0);
        aif.req = aif.req & ~aif.resp_valid;
      end
    end
    tick();
    chk("t2_idle", aif.busy, 0);
    chk("t2_all_served", exp_q.size(), 0);

    // req0 held, req1 pulsed: owners alternate
    do_reset();
    set_op(0, 32'd1, 32'd1, 3'd0);
    set_op(1, 32'd9, 32'd4, 3'd1);
    aif.req  = 3'b011;
    req1_low = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      tick();
      chk("t3_grant", aif.grant, (c % 2 == 1) ? oh(((c - 1) / 2) % 2) : 3'b000);
      chk("t3_resp_valid", aif.resp_valid, (c % 2 == 0) ? oh((c / 2 - 1) % 2) : 3'b000);
      if (c % 2 == 0) chk("t3_resp_data", aif.resp_data, (((c / 2 - 1) % 2) == 0) ? 2 : 5);
      if (req1_low) begin
        aif.req[1] = 1'b1;
        req1_low   = 1'b0;
      end
      if (aif.resp_valid[1]) begin
        aif.req[1] = 1'b0;
        req1_low   = 1'b1;
      end
    end
    aif.req = '0;
    tick();
    tick();

    // requester 2 alone, re-raising right after each response
    do_reset();
    set_op(2, 32'd100, 32'd1, 3'd1);
    aif.req  = 3'b100;
    req2_low = 1'b0;
    for (int c = 1; c <= 9; c++) begin
      tick();
      chk("t4_grant", aif.grant, (c % 3 == 1) ? 3'b100 : 3'b000);
      chk("t4_resp_valid", aif.resp_valid, (c % 3 == 2) ? 3'b100 : 3'b000);
      chk("t4_busy", aif.busy, (c % 3 == 0) ? 1'b0 : 1'b1);
      if (c % 3 == 2) chk("t4_resp_data", aif.resp_data, 99);
      if (req2_low) begin
        aif.req[2] = 1'b1;
        req2_low   = 1'b0;
      end
      if (aif.resp_valid[2]) begin
        aif.req[2] = 1'b0;
        req2_low   = 1'b1;
      end
    end
    chk("t4_last_owner", aif.dbg_last_owner, 2);
    aif.req = '0;
    tick();
    tick();

    // reset asserted during EXEC
    do_reset();
    set_op(0, 32'd1, 32'd1, 3'd0);
    aif.req = 3'b001;
    tick();
    chk("t5_grant_exec", aif.grant, 3'b001);
    chk("t5_state_exec", aif.dbg_state, 1);
    reset = 1'b1;
    tick();
    chk("t5_state", aif.dbg_state, 0);
    chk("t5_grant", aif.grant, 0);
    chk("t5_resp_valid", aif.resp_valid, 0);
    chk("t5_alu_a", aif.alu_a, 0);
    chk("t5_alu_b", aif.alu_b, 0);
    chk("t5_alu_op", aif.alu_op, 0);
    chk("t5_busy", aif.busy, 0);
    aif.req = '0;
    reset   = 1'b0;
    tick();
    chk("t5_no_resp", aif.resp_valid, 0);

    // req dropped and operands changed during EXEC: op still completes with the registered operands
    set_op(0, 32'd16, 32'd1, 3'd0);
    aif.req = 3'b001;
    tick();
    chk("t7_grant", aif.grant, 3'b001);
    set_op(0, 32'd999, 32'd5, 3'd1);
    aif.req = '0;
    tick();
    chk("t7_resp_valid", aif.resp_valid, 3'b001);
    chk("t7_resp_data", aif.resp_data, 17);
    tick();
    chk("t7_idle", aif.busy, 0);

    // quiet bus for 10 cycles
    for (int c = 0; c < 10; c++) begin
      tick();
      chk("t6_busy", aif.busy, 0);
      chk("t6_grant", aif.grant, 0);
      chk("t6_alu_a", aif.alu_a, 0);
      chk("t6_alu_op", aif.alu_op, 0);
      chk("t6_resp_data", aif.resp_data, 17);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
